// File: rtl/simd2_pkg.sv
// Shared types and constants for the simd2 command sequencer.
package simd2_pkg;

   localparam int SIMD_LANES = 10;
   localparam int SIMD_DW    = 16;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } seq_state_t;

   // One queued command for the simd2 unit
   typedef struct packed {
      logic [3:0] x;
      logic [1:0] op;
   } simd_cmd_t;

endpackage

// File: rtl/simd2_cmd_fifo.sv
// Command FIFO: synchronous, DEPTH entries (power of 2), no bypass path.
// Pushes are refused when full regardless of a same-cycle pop.
module simd2_cmd_fifo
   import simd2_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  logic      pop,
   input  simd_cmd_t push_data,
   output simd_cmd_t pop_data,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   simd_cmd_t      mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q;
   logic [AW:0]    rd_ptr_q;
   logic           do_push_s;
   logic           do_pop_s;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;
   assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];

   // Storage and pointer update, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
            wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/simd2_sequencer.sv
// Command sequencer for the simd2 vector unit: queues (x, opcode) commands,
// issues them one at a time, waits the unit latency, snapshots all lanes and
// streams them out one lane per handshake, strictly in command order.
module simd2_sequencer
   import simd2_pkg::*;
#(
   parameter int LANES = SIMD_LANES,
   parameter int DW    = SIMD_DW,
   parameter int LAT   = 1,
   parameter int DEPTH = 4
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [3:0]          cmd_x,
   input  logic [1:0]          cmd_op,
   output logic [3:0]          simd_x,
   output logic [1:0]          simd_opcode,
   input  logic [LANES*DW-1:0] simd_result,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [DW-1:0]       res_data,
   output logic [3:0]          res_lane,
   output logic                res_last,
   output logic                busy
);

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   seq_state_t          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [3:0]          lane_q, lane_d;
   logic [LANES*DW-1:0] snap_q, snap_d;
   logic [3:0]          x_q, x_d;
   logic [1:0]          op_q, op_d;
   logic                res_valid_q, res_valid_d;
   logic                res_last_q, res_last_d;

   simd_cmd_t           fifo_in_s;
   simd_cmd_t           fifo_head_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic                fifo_pop_s;

   assign fifo_in_s = '{x: cmd_x, op: cmd_op};

   simd2_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cmd_valid && rst_n),
      .pop       (fifo_pop_s),
      .push_data (fifo_in_s),
      .pop_data  (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Ready depends only on FIFO occupancy (and is held low during reset)
   assign cmd_ready   = rst_n && !fifo_full_s;
   assign simd_x      = x_q;
   assign simd_opcode = op_q;
   assign res_valid   = res_valid_q;
   assign res_last    = res_last_q;
   assign res_lane    = lane_q;
   assign res_data    = snap_q[int'(lane_q)*DW +: DW];
   assign busy        = (state_q != IDLE) || !fifo_empty_s;

   // Next-state logic: issue from FIFO, count out latency, drain lanes
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lane_d      = lane_q;
      snap_d      = snap_q;
      x_d         = x_q;
      op_d        = op_q;
      res_valid_d = res_valid_q;
      res_last_d  = res_last_q;
      fifo_pop_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty_s) begin
               fifo_pop_s = 1'b1;
               x_d        = fifo_head_s.x;
               op_d       = fifo_head_s.op;
               cnt_d      = CW'(LAT - 1);
               state_d    = WAIT;
            end else begin
               state_d    = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == {CW{1'b0}}) begin
               snap_d      = simd_result;
               lane_d      = 4'd0;
               res_valid_d = 1'b1;
               res_last_d  = (LANES == 1);
               state_d     = DRAIN;
            end else begin
               cnt_d       = cnt_q - CW'(1);
            end
         end
         DRAIN: begin
            if (res_ready) begin
               if (lane_q == 4'(LANES - 1)) begin
                  res_valid_d = 1'b0;
                  res_last_d  = 1'b0;
                  lane_d      = 4'd0;
                  state_d     = IDLE;
               end else begin
                  lane_d      = lane_q + 4'd1;
                  res_last_d  = (lane_q == 4'(LANES - 2));
               end
            end else begin
               lane_d      = lane_q;
            end
         end
         default: begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         lane_q      <= 4'd0;
         snap_q      <= '0;
         x_q         <= 4'd0;
         op_q        <= 2'd0;
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lane_q      <= lane_d;
         snap_q      <= snap_d;
         x_q         <= x_d;
         op_q        <= op_d;
         res_valid_q <= res_valid_d;
         res_last_q  <= res_last_d;
      end
   end

endmodule

// File: doc/simd2_sequencer.md
# simd2_sequencer

Command sequencer for the `simd2` vector unit. It queues `(x, opcode)` commands from an upstream requester and issues them one at a time to `simd2`. It waits the unit's fixed result latency, snapshots all ten 16-bit lane outputs, and streams them out one lane per handshake. It sits between the core's issue logic and `simd2`, and is the only block that drives `simd2`'s `x`/`opcode` inputs.

## Interface
Parameters:
- `LANES`, 10, number of `simd2` result lanes.
- `DW`, 16, lane width in bits.
- `LAT`, 1, clock edges from a `simd_x`/`simd_opcode` change to valid `simd_result`. Must be at least 1.
- `DEPTH`, 4, command FIFO depth. Must be a power of 2.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_x`  in  4  operand for `simd2`.
- `cmd_op`  in  2  opcode for `simd2`.
- `simd_x`  out  4  registered drive to `simd2.x`.
- `simd_opcode`  out  2  registered drive to `simd2.opcode`.
- `simd_result`  in  LANES*DW  concatenated `simd2` outputs; lane 0 (`output_one`) occupies bits [15:0].
- `res_valid`  out  1  result lane available.
- `res_ready`  in  1  downstream accepts the lane.
- `res_data`  out  DW  current lane value.
- `res_lane`  out  4  lane index, 0..LANES-1.
- `res_last`  out  1  high with the final lane of a command.
- `busy`  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- **Command accept:** a command is accepted on any cycle with `cmd_valid && cmd_ready`.
  - `cmd_ready` = FIFO not full, and is forced 0 while `rst_n` = 0.
  - There is no bypass. A push into a full FIFO is impossible, even if a pop happens in the same cycle.
- **FSM states:** IDLE, WAIT, DRAIN.
  - **IDLE:** if the FIFO is non-empty, pop the head, register it onto `simd_x`/`simd_opcode`, load `cnt` = LAT-1, and go to WAIT. Otherwise stay in IDLE.
  - **WAIT:** decrement `cnt` each cycle. In the cycle where `cnt` = 0, register all of `simd_result` into the shadow register `snap`, set `lane` = 0, and go to DRAIN.
  - **DRAIN:** `res_valid` = 1, `res_data` = `snap[lane]`, `res_lane` = `lane`, `res_last` = (`lane` == LANES-1).
    - On a handshake with `lane` < LANES-1, increment `lane`.
    - On a handshake with `res_last` high, go to IDLE.
- **Held values:** `simd_x`/`simd_opcode` keep the last issued command until the next pop; they never return to 0 except on reset.
- **Ordering:** results leave strictly in command order. Pushes continue during WAIT and DRAIN.
- **Output stability:** while `res_valid` is high and `res_ready` is low, `res_data`, `res_lane` and `res_last` hold stable.
- **Reset values** (any cycle with `rst_n` = 0, including mid-WAIT or mid-DRAIN):
  - FSM → IDLE, FIFO emptied, `cnt`/`lane`/`snap` → 0.
  - `simd_x` = 0, `simd_opcode` = 0.
  - `res_valid` = 0, `res_last` = 0, `res_data` = 0, `res_lane` = 0, `busy` = 0, `cmd_ready` = 0.
  - An in-flight command is discarded; no partial stream resumes.

## Timing
- **Latency:** for a command accepted in cycle N into an empty FIFO with the FSM in IDLE:
  - pop in N+1;
  - `simd_x` valid from N+2;
  - `snap` captured at the end of cycle N+1+LAT;
  - first `res_valid` in N+2+LAT. With LAT=1, that is N+3.
- **Stream length:** with `res_ready` tied high, a command occupies DRAIN for exactly LANES cycles.
- **Command-to-command gap:** one IDLE cycle separates consecutive commands. Throughput is one command per LANES+LAT+1 cycles.
- **Output timing:** `res_*` come from registers or the `snap` mux only, with no combinational path from `simd_result`. `cmd_ready` depends only on FIFO state, with no path from `cmd_valid`.

## Structure
- **Package `simd2_pkg`:**
  - FSM state enum `seq_state_t` {IDLE, WAIT, DRAIN};
  - constants `SIMD_LANES` = 10, `SIMD_DW` = 16;
  - command struct `simd_cmd_t` {x[3:0], op[1:0]}.
- **Sub-module `simd2_cmd_fifo`:** synchronous FIFO with ports push/pop/full/empty and data = `simd_cmd_t`, parameterised by DEPTH, with synchronous active-low reset.
- The FSM, counters and `snap` live in the top level.

## Test plan
- **Single command:** `simd2` model returns lane i = 16'h0100+i. Push x=4'd3, op=2'b01 at cycle N with `res_ready`=1.
  - → `simd_x`=3 and `simd_opcode`=1 from N+2.
  - → `res_valid` rises at N+3.
  - → `res_data` = 16'h0100..16'h0109 with `res_lane` 0..9.
  - → `res_last` high only on lane 9.
  - → `busy` low at N+13.
- **Back-pressure:** same command, `res_ready` toggling 1,0,1,0.
  - → each lane is held stable while `res_ready`=0.
  - → exactly 10 handshakes with no duplicated or skipped lanes.
- **FIFO full:** `res_ready`=0, `cmd_valid` held high with 7 distinct commands.
  - → 5 accepted (1 popped plus 4 queued), then `cmd_ready`=0.
  - → after `res_ready`=1, results for the 5 commands emerge in push order.
- **Back-to-back commands:** two commands queued, `res_ready`=1.
  - → the second stream's lane 0 appears exactly LAT+2 cycles after the first stream's `res_last` handshake.
- **Reset mid-DRAIN:** assert `rst_n`=0 for 1 cycle during lane 4 of a stream with 2 commands queued.
  - → next cycle all outputs are at reset values and `busy`=0.
  - → no further `res_valid` until a new command is pushed.
